// File: rtl/cim_shift_accumulator_if.sv
// Handshake bundle between the SparseCIM adder tree, the shift accumulator and
// the result consumer.
//   master : drives start, psum_valid, psum, out_ready (tree/control side)
//   slave  : drives psum_ready, out_valid, out_data, busy (the accumulator)
interface cim_shift_accumulator_if #(
  parameter int PSUM_W  = 10,
  parameter int IN_BITS = 4,
  parameter int ACC_W   = PSUM_W + IN_BITS
);
  logic              start;
  logic              psum_valid;
  logic [PSUM_W-1:0] psum;
  logic              psum_ready;
  logic              out_valid;
  logic [ACC_W-1:0]  out_data;
  logic              out_ready;
  logic              busy;

  modport master (
    output start, psum_valid, psum, out_ready,
    input  psum_ready, out_valid, out_data, busy
  );

  modport slave (
    input  start, psum_valid, psum, out_ready,
    output psum_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/cim_shift_accumulator.sv
// Bit-serial shift-and-add accumulator behind the SparseCIM 64-row adder tree.
// One unsigned partial sum arrives per activation bit-plane, MSB plane first;
// IN_BITS planes are folded into acc = (acc << 1) + psum and the finished dot
// product is offered on a valid/ready output.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous, active-high reset
//   bus  - slave side of cim_shift_accumulator_if:
//          start, psum_valid/psum/psum_ready (plane input),
//          out_valid/out_data/out_ready (result output), busy
// All outputs decode from registers only; no input-to-output comb path.
module cim_shift_accumulator #(
  parameter int PSUM_W  = 10,
  parameter int IN_BITS = 4,
  parameter int ACC_W   = PSUM_W + IN_BITS
) (
  input  logic                    clk,
  input  logic                    rst,
  cim_shift_accumulator_if.slave  bus
);

  localparam int CNT_W = (IN_BITS > 1) ? $clog2(IN_BITS) : 1;
  localparam logic [CNT_W-1:0] LAST_PLANE = CNT_W'(IN_BITS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] bit_cnt;

  // Weight the running sum by one binary place and add the new plane.
  // Width is sized so the worst case cannot wrap.
  function automatic logic [ACC_W-1:0] shift_add(
    input logic [ACC_W-1:0]  acc_in,
    input logic [PSUM_W-1:0] psum_in
  );
    return (acc_in << 1) + ACC_W'(psum_in);
  endfunction

  // State / accumulate stage
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      acc     <= '0;
      bit_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            acc     <= '0;
            bit_cnt <= '0;
            state   <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (bus.psum_valid) begin
            acc <= shift_add(acc, bus.psum);
            if (bit_cnt == LAST_PLANE) begin
              state <= S_DONE;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            if (bus.start) begin
              // Back-to-back: skip IDLE so a new result can start immediately.
              acc     <= '0;
              bit_cnt <= '0;
              state   <= S_ACCUM;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Output decode stage (registered state only)
  assign bus.psum_ready = (state == S_ACCUM);
  assign bus.out_valid  = (state == S_DONE);
  assign bus.busy       = (state == S_ACCUM) || (state == S_DONE);
  assign bus.out_data   = acc;

endmodule

// File: doc/cim_shift_accumulator.md
# cim_shift_accumulator

Bit-serial shift-and-add accumulator directly downstream of the SparseCIM 64-row adder tree (the 32 two-input 4-bit adders and the levels above them). Activations enter the macro one bit-plane per cycle, MSB first. For each bit-plane, the tree produces one unsigned partial sum. This block weights and accumulates IN_BITS such partial sums into one full-precision dot-product result and presents it on a valid/ready output port.

## Interface
Parameters:
- PSUM_W, 10: partial-sum width; 64 rows x max 15 = 960 fits in 10 bits.
- IN_BITS, 4: activation bit-planes per dot product; must be >= 2.
- ACC_W, PSUM_W+IN_BITS: result width; derived, do not override.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, synchronous and active-high.
- start  input  1  begin a new dot product; honoured only as defined under Operation.
- psum_valid  input  1  psum carries a bit-plane partial sum.
- psum  input  PSUM_W  unsigned partial sum from the adder tree.
- psum_ready  output  1  block accepts psum this cycle.
- out_valid  output  1  out_data holds a completed result.
- out_data  output  ACC_W  unsigned accumulated result.
- out_ready  input  1  consumer accepts out_data.
- busy  output  1  high in ACCUM or DONE.

## Operation
- States: IDLE, ACCUM, DONE. Support registers are acc[ACC_W-1:0] and bit_cnt, sized clog2(IN_BITS).
- IDLE:
  - psum_ready=0 and out_valid=0.
  - On start=1: acc<=0, bit_cnt<=0, move to ACCUM.
  - psum_valid in IDLE is ignored.
- ACCUM:
  - psum_ready=1.
  - A psum handshake is psum_valid=1 in ACCUM. On each handshake, acc<=(acc<<1)+psum, zero-extended.
  - If bit_cnt==IN_BITS-1 on that handshake, move to DONE. Otherwise bit_cnt<=bit_cnt+1.
  - Cycles with psum_valid=0 hold all state (gaps allowed).
  - start is ignored in ACCUM.
- DONE:
  - out_valid=1 and out_data=acc, held stable until the output handshake (out_valid & out_ready).
  - psum_ready=0.
  - On output handshake with start=0: go to IDLE.
  - On output handshake with start=1 in the same cycle: acc<=0, bit_cnt<=0, go directly to ACCUM (back-to-back operation).
  - start without out_ready is ignored.
- Result equals the sum over k of psum_k * 2^(IN_BITS-1-k), where k=0 is the first (MSB) plane.
- Arithmetic is unsigned and cannot overflow. Worst case is (2^PSUM_W - 1)(2^IN_BITS - 1) < 2^ACC_W.
- out_data is driven from acc in all states. It is meaningful only while out_valid=1.

## Timing
- Reset values: state=IDLE, acc=0, bit_cnt=0, psum_ready=0, out_valid=0, out_data=0, busy=0.
- rst has priority over every other input in the same cycle. Reset mid-ACCUM or mid-DONE discards the partial or pending result; no out_valid follows.
- start sampled at edge N moves the block to ACCUM, so psum_ready=1 from cycle N+1.
- Final psum handshake at edge M gives out_valid=1 in cycle M+1. This is 1 cycle of latency after the last plane.
- Minimum period per result is IN_BITS+1 cycles, using back-to-back start with out_ready held high.
- psum_ready, out_valid and busy are decoded from registered state only. There is no combinational path from any input to any output.

## Test plan
- Basic: start, then psum 5,3,0,7 on consecutive cycles -> out_valid one cycle after the 7; out_data=59; returns to IDLE when out_ready=1.
- Max value: four psums of 960 -> out_data=14400 with no wrap. Also four psums of 0 -> out_data=0 with out_valid still asserted.
- Gaps and backpressure:
  - psum_valid low for 2 cycles between planes 1 and 2 (psums 1,2,3,4) -> out_data=26.
  - out_ready held low 3 cycles -> out_valid and out_data stay stable until accepted.
- Ignored inputs:
  - psum_valid=1 with psum=9 in IDLE -> no effect; the next run of 1,1,1,1 gives 15.
  - start pulsed mid-ACCUM -> no restart, result unchanged.
- Back-to-back: in DONE, out_ready=1 and start=1 together -> next cycle is ACCUM with acc=0; second run 0,0,0,1 gives 1.
- Reset mid-op: rst after 2 of 4 planes -> all outputs at reset values next cycle, no out_valid. A fresh run 2,0,0,0 gives 16.
